tabby_event_mbox: RTL



---
 rtl/tabby_mbox_pkg.sv | 29 ++
 rtl/tabby_mbox_fifo.sv | 55 +++++
 rtl/tabby_event_mbox.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/tabby_mbox_pkg.sv
// Shared constants for the tabby event mailbox: register map, IRQ source bits,
// STATUS field positions and a byte-lane helper for partial register writes.
package tabby_mbox_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_DATA     = 3'd1;
  localparam logic [2:0] ADDR_IRQ_EN   = 3'd2;
  localparam logic [2:0] ADDR_IRQ_PEND = 3'd3;
  localparam logic [2:0] ADDR_THRESH   = 3'd4;
  localparam logic [2:0] ADDR_TSTAMP   = 3'd5;

  localparam int IRQ_PUSH = 0;
  localparam int IRQ_THR  = 1;
  localparam int IRQ_OVF  = 2;
  localparam int NUM_IRQ  = 3;

  localparam int STAT_EMPTY = 16;
  localparam int STAT_FULL  = 17;
  localparam int STAT_OVF   = 18;

  localparam int EV_W = 32;
  localparam int TS_W = 32;

  // True when the byte lane holding register bit idx is enabled.
  function automatic logic byte_lane_en(input logic [3:0] be, input int idx);
    return be[idx/8];
  endfunction

endpackage

// File: rtl/tabby_mbox_fifo.sv
// Synchronous show-ahead FIFO; head_data is the oldest entry whenever not empty.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module tabby_mbox_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  q_clock,
  input  logic                  q_reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      push_data,
  output logic [WIDTH-1:0]      head_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  // When full, wr_ptr == rd_ptr; the old head is read this cycle before the
  // overwrite lands at the clock edge.
  always_ff @(posedge q_clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge q_clock or posedge q_reset) begin
    if (q_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/tabby_event_mbox.sv
// Avalon-MM event mailbox: fabric pushes event words, host pops them via DATA.
// Optional TABBY_MBOX_TIMESTAMP_EN stores a cycle stamp with each word.
module tabby_event_mbox
  import tabby_mbox_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset,
  input  logic [2:0]  avs_S1_address,
  input  logic        avs_S1_read,
  input  logic        avs_S1_write,
  input  logic [31:0] avs_S1_writedata,
  input  logic [3:0]  avs_S1_byteenable,
  output logic [31:0] avs_S1_readdata,
  output logic        avs_S1_readdatavalid,
  output logic        avs_S1_waitrequest,
  input  logic [31:0] asi_EV_data,
  input  logic        asi_EV_valid,
  output logic        ins_IRQ_irq
);

  localparam int LW = DEPTH_LOG2 + 1;
`ifdef TABBY_MBOX_TIMESTAMP_EN
  localparam int FW = EV_W + TS_W;
`else
  localparam int FW = EV_W;
`endif

  logic q_clock;
  logic q_reset;
  assign q_clock = csi_MCLK_clk;
  assign q_reset = rsi_MRST_reset;

  logic               rd_acc;
  logic               wr_acc;
  logic               push;
  logic               pop;
  logic               drop;
  logic               thr_hit;
  logic [FW-1:0]      fifo_in;
  logic [FW-1:0]      fifo_head;
  logic [LW-1:0]      level;
  logic               full;
  logic               empty;

  logic [NUM_IRQ-1:0] irq_en;
  logic [NUM_IRQ-1:0] irq_pend;
  logic [LW-1:0]      thresh;
  logic               ovf_seen;

  logic [NUM_IRQ-1:0] irq_en_nxt;
  logic [NUM_IRQ-1:0] pend_clr;
  logic [NUM_IRQ-1:0] pend_set;
  logic [NUM_IRQ-1:0] pend_nxt;
  logic [LW-1:0]      thresh_nxt;
  logic               ovf_nxt;
  logic [31:0]        status_word;
  logic [31:0]        rd_word;

  assign avs_S1_waitrequest = 1'b0;

  // Read wins if the bridge ever asserts both strobes.
  assign rd_acc  = avs_S1_read;
  assign wr_acc  = avs_S1_write && !avs_S1_read;
  assign pop     = rd_acc && (avs_S1_address == ADDR_DATA) && !empty;
  assign push    = asi_EV_valid && (!full || pop);
  assign drop    = asi_EV_valid && !push;
  assign thr_hit = push && !pop && (thresh != '0) && ((level + LW'(1)) == thresh);

`ifdef TABBY_MBOX_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] tstamp;

  assign fifo_in = {ts_cnt, asi_EV_data};

  always_ff @(posedge q_clock or posedge q_reset) begin
    if (q_reset) begin
      ts_cnt <= '0;
      tstamp <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (pop) tstamp <= fifo_head[FW-1:EV_W];
    end
  end
`else
  assign fifo_in = asi_EV_data;
`endif

  tabby_mbox_fifo #(
    .WIDTH      (FW),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .q_clock   (q_clock),
    .q_reset   (q_reset),
    .push      (push),
    .pop       (pop),
    .push_data (fifo_in),
    .head_data (fifo_head),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    irq_en_nxt = irq_en;
    thresh_nxt = thresh;
    pend_clr   = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (wr_acc && (avs_S1_address == ADDR_IRQ_EN) && byte_lane_en(avs_S1_byteenable, i))
        irq_en_nxt[i] = avs_S1_writedata[i];
      if (wr_acc && (avs_S1_address == ADDR_IRQ_PEND) && byte_lane_en(avs_S1_byteenable, i))
        pend_clr[i] = avs_S1_writedata[i];
    end
    for (int i = 0; i < LW; i++) begin
      if (wr_acc && (avs_S1_address == ADDR_THRESH) && byte_lane_en(avs_S1_byteenable, i))
        thresh_nxt[i] = avs_S1_writedata[i];
    end
  end

  // A same-cycle set beats the host's W1C.
  always_comb begin
    pend_set           = '0;
    pend_set[IRQ_PUSH] = push;
    pend_set[IRQ_THR]  = thr_hit;
    pend_set[IRQ_OVF]  = drop;
    pend_nxt           = (irq_pend & ~pend_clr) | pend_set;
    ovf_nxt            = (ovf_seen && !pend_clr[IRQ_OVF]) || drop;
  end

  always_comb begin
    status_word             = '0;
    status_word[LW-1:0]     = level;
    status_word[STAT_EMPTY] = empty;
    status_word[STAT_FULL]  = full;
    status_word[STAT_OVF]   = ovf_seen;
  end

  always_comb begin
    rd_word = '0;
    case (avs_S1_address)
      ADDR_STATUS:   rd_word = status_word;
      ADDR_DATA:     rd_word = empty ? 32'h0 : fifo_head[EV_W-1:0];
      ADDR_IRQ_EN:   rd_word[NUM_IRQ-1:0] = irq_en;
      ADDR_IRQ_PEND: rd_word[NUM_IRQ-1:0] = irq_pend;
      ADDR_THRESH:   rd_word[LW-1:0] = thresh;
`ifdef TABBY_MBOX_TIMESTAMP_EN
      ADDR_TSTAMP:   rd_word = tstamp;
`endif
      default:       rd_word = '0;
    endcase
  end

  always_ff @(posedge q_clock or posedge q_reset) begin
    if (q_reset) begin
      irq_en               <= '0;
      irq_pend             <= '0;
      thresh               <= '0;
      ovf_seen             <= 1'b0;
      ins_IRQ_irq          <= 1'b0;
      avs_S1_readdata      <= '0;
      avs_S1_readdatavalid <= 1'b0;
    end else begin
      irq_en               <= irq_en_nxt;
      irq_pend             <= pend_nxt;
      thresh               <= thresh_nxt;
      ovf_seen             <= ovf_nxt;
      ins_IRQ_irq          <= |(irq_pend & irq_en);
      avs_S1_readdatavalid <= rd_acc;
      if (rd_acc) avs_S1_readdata <= rd_word;
    end
  end

  logic unused_wr_bits;
  assign unused_wr_bits = ^{avs_S1_writedata, avs_S1_byteenable};

endmodule
